// File: rtl/rsa4k_pkg.sv
// rtl/rsa4k_pkg.sv - shared rsa4k widths and loader FSM state encoding
package rsa4k_pkg;

    localparam int WIDTH = 4096;
    localparam int WORD  = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_MSG = 3'd1,
        LOAD_EXP = 3'd2,
        LOAD_MOD = 3'd3,
        ARM      = 3'd4,
        RUN      = 3'd5,
        UNLOAD   = 3'd6
    } state_t;

endpackage

// File: rtl/rsa4k_word_sel.sv
// rtl/rsa4k_word_sel.sv - combinational WIDTH-to-WORD word mux indexed by word number
module rsa4k_word_sel #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32,
    localparam int NWORDS = WIDTH / WORD,
    localparam int CW     = $clog2(NWORDS)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CW-1:0]    sel,
    output logic [WORD-1:0]  word
);

    assign word = data[sel*WORD +: WORD];

endmodule

// File: rtl/rsa4k_stream_loader.sv
// rtl/rsa4k_stream_loader.sv - word-serial operand loader and result unloader for rsa4k
module rsa4k_stream_loader
    import rsa4k_pkg::*;
#(
    parameter int WIDTH = rsa4k_pkg::WIDTH,
    parameter int WORD  = rsa4k_pkg::WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WORD-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WORD-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic [WIDTH-1:0] message,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] modulus,
    output logic             go,
    input  logic [WIDTH-1:0] cypher,
    input  logic             done
);

    localparam int NWORDS = WIDTH / WORD;
    localparam int CW     = $clog2(NWORDS);

    state_t            state;
    logic [CW-1:0]     word_cnt;
    logic [WIDTH-1:0]  result;
    logic              in_xfer;
    logic              out_xfer;
    logic              last_word;

    assign in_xfer   = s_valid & s_ready;
    assign out_xfer  = m_valid & m_ready;
    assign last_word = (word_cnt == CW'(NWORDS - 1));

    // m_data follows word_cnt over the frozen result, so it is stable while stalled
    rsa4k_word_sel #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_word_sel (
        .data (result),
        .sel  (word_cnt),
        .word (m_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            result   <= '0;
            message  <= '0;
            exponent <= '0;
            modulus  <= '0;
            s_ready  <= 1'b0;
            m_valid  <= 1'b0;
            go       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (in_xfer) begin
                        message[word_cnt*WORD +: WORD] <= s_data;
                        word_cnt <= word_cnt + 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD_MSG;
                    end
                end
                LOAD_MSG: begin
                    if (in_xfer) begin
                        message[word_cnt*WORD +: WORD] <= s_data;
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            state <= LOAD_EXP;
                        end
                    end
                end
                LOAD_EXP: begin
                    if (in_xfer) begin
                        exponent[word_cnt*WORD +: WORD] <= s_data;
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            state <= LOAD_MOD;
                        end
                    end
                end
                LOAD_MOD: begin
                    if (in_xfer) begin
                        modulus[word_cnt*WORD +: WORD] <= s_data;
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            s_ready <= 1'b0;
                            state   <= ARM;
                        end
                    end
                end
                ARM: begin
                    // a done left high by the previous job must clear before go
                    if (!done) begin
                        go    <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (done) begin
                        result  <= cypher;
                        go      <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (out_xfer) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_word) begin
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa4k_stream_loader.sv
// tb/tb_rsa4k_stream_loader.sv - directed bench for rsa4k_stream_loader with a behavioural core
module tb_rsa4k_stream_loader;
    import rsa4k_pkg::*;

    localparam int NW = WIDTH / WORD;

    logic             clk = 1'b0;
    logic             reset;
    logic [WORD-1:0]  s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WORD-1:0]  m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic [WIDTH-1:0] message;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             go;
    logic [WIDTH-1:0] cypher;
    logic             done;

    logic             core_done;
    logic             force_done;
    int               core_cnt;

    int compared   = 0;
    int mismatched = 0;
    int stall_err  = 0;
    logic             prev_stall = 1'b0;
    logic [WORD-1:0]  prev_data  = '0;

    rsa4k_stream_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy),
        .message  (message),
        .exponent (exponent),
        .modulus  (modulus),
        .go       (go),
        .cypher   (cypher),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign done = core_done | force_done;

    // small operands get a real modexp; wide ones a cheap mixing function
    function automatic logic [WIDTH-1:0] core_f(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                                                input logic [WIDTH-1:0] n);
        longint unsigned r, b, md;
        if (m[WIDTH-1:32] == '0 && e[WIDTH-1:32] == '0 && n[WIDTH-1:32] == '0 && n[31:0] != 0) begin
            md = 64'(n[31:0]);
            b  = 64'(m[31:0]) % md;
            r  = 1;
            for (int i = 0; i < 32; i++) begin
                if (e[i]) r = (r * b) % md;
                b = (b * b) % md;
            end
            return WIDTH'(r);
        end
        return m ^ {e[WIDTH-2:0], e[WIDTH-1]} ^ ~n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
            cypher    <= '0;
        end else if (!go) begin
            core_done <= 1'b0;
            core_cnt  <= 0;
        end else if (!core_done) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 4) begin
                core_done <= 1'b1;
                cypher    <= core_f(message, exponent, modulus);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (prev_stall && (m_data !== prev_data || m_valid !== 1'b1)) stall_err++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int diff_words(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int d = 0;
        for (int i = 0; i < NW; i++) if (a[i*WORD +: WORD] !== b[i*WORD +: WORD]) d++;
        return d;
    endfunction

    function automatic logic [WORD-1:0] stream_word(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                                                    input logic [WIDTH-1:0] n, input int i);
        if (i < NW)     return m[i*WORD +: WORD];
        if (i < 2 * NW) return e[(i-NW)*WORD +: WORD];
        return n[(i-2*NW)*WORD +: WORD];
    endfunction

    task automatic send_range(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] n,
                              input int from, input int to, input int gap_pct);
        int t;
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            while ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = stream_word(m, e, n, i);
            t = 0;
            while (!s_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) begin
                check("s_ready_timeout", 64'(i), 64'(-1));
                s_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int t = 0;
        while (!go && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(go), 64'd1);
    endtask

    task automatic recv(input int pct, output logic [WIDTH-1:0] got, output int n);
        int t = 0;
        n   = 0;
        got = '0;
        while (n < NW && t < 20000) begin
            @(negedge clk);
            m_ready = ($urandom_range(99) < pct);
            if (m_valid && m_ready) begin
                got[n*WORD +: WORD] = m_data;
                n++;
            end
            t++;
        end
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] op_m, op_e, op_n, got, expv;
    int               nrx;
    int               viol;
    int               t;

    initial begin
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 0);
        check("rst_m_valid", 64'(m_valid), 0);
        check("rst_go", 64'(go), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_m_data", 64'(m_data), 0);
        check("rst_operands", 64'(|{message, exponent, modulus}), 0);
        reset = 1'b0;

        // test 1: 8^13 mod 77 = 50, with go and m_valid latency checks
        op_m = WIDTH'(8); op_e = WIDTH'(13); op_n = WIDTH'(77);
        send_range(op_m, op_e, op_n, 0, 3 * NW, 0);
        check("t1_arm_go", 64'(go), 0);
        check("t1_arm_s_ready", 64'(s_ready), 0);
        check("t1_arm_busy", 64'(busy), 1);
        @(negedge clk);
        check("t1_go_rise", 64'(go), 1);
        check("t1_operands", 64'(diff_words(message, op_m) + diff_words(exponent, op_e)
                                 + diff_words(modulus, op_n)), 0);
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t1_done_seen", 64'(done), 1);
        check("t1_m_valid_pre", 64'(m_valid), 0);
        @(negedge clk);
        check("t1_m_valid_next", 64'(m_valid), 1);
        check("t1_go_fall", 64'(go), 0);
        recv(100, got, nrx);
        check("t1_count", 64'(nrx), 64'(NW));
        check("t1_word0", 64'(got[31:0]), 64'h32);
        check("t1_result", 64'(diff_words(got, WIDTH'(50))), 0);
        check("t1_idle_busy", 64'(busy), 0);
        check("t1_idle_m_valid", 64'(m_valid), 0);
        check("t1_idle_s_ready", 64'(s_ready), 1);

        // test 2: 50^37 mod 77 = 8, back-to-back, with a stale done held in ARM
        op_m = WIDTH'(50); op_e = WIDTH'(37); op_n = WIDTH'(77);
        send_range(op_m, op_e, op_n, 0, 3 * NW, 0);
        force_done = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_stale_go", 64'(go), 0);
        check("t2_stale_s_ready", 64'(s_ready), 0);
        check("t2_stale_busy", 64'(busy), 1);
        force_done = 1'b0;
        wait_go("t2_go");
        recv(100, got, nrx);
        check("t2_count", 64'(nrx), 64'(NW));
        check("t2_word0", 64'(got[31:0]), 64'h8);
        check("t2_result", 64'(diff_words(got, WIDTH'(8))), 0);

        // test 3: random wide operands, input gaps and 50% m_ready
        for (int i = 0; i < NW; i++) begin
            op_m[i*WORD +: WORD] = $urandom;
            op_e[i*WORD +: WORD] = $urandom;
            op_n[i*WORD +: WORD] = $urandom;
        end
        stall_err = 0;
        send_range(op_m, op_e, op_n, 0, 3 * NW, 30);
        check("t3_operands", 64'(diff_words(message, op_m) + diff_words(exponent, op_e)
                                 + diff_words(modulus, op_n)), 0);
        wait_go("t3_go");
        expv = op_m ^ {op_e[WIDTH-2:0], op_e[WIDTH-1]} ^ ~op_n;
        recv(50, got, nrx);
        check("t3_count", 64'(nrx), 64'(NW));
        check("t3_result", 64'(diff_words(got, expv)), 0);
        check("t3_stall_stable", 64'(stall_err), 0);
        check("t3_no_extra", 64'(m_valid), 0);

        // test 6: m_ready held low for 2000 cycles after done
        op_m = WIDTH'(8); op_e = WIDTH'(13); op_n = WIDTH'(77);
        send_range(op_m, op_e, op_n, 0, 3 * NW, 0);
        t = 0;
        while (!m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_m_valid_rise", 64'(m_valid), 1);
        viol = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!(m_valid && m_data == 32'h32 && !s_ready && busy && !go)) viol++;
        end
        check("t6_hold_violations", 64'(viol), 0);
        recv(100, got, nrx);
        check("t6_result", 64'(diff_words(got, WIDTH'(50))), 0);

        // test 5: done forced high during LOAD_MSG is ignored
        op_m = WIDTH'(50); op_e = WIDTH'(37); op_n = WIDTH'(77);
        send_range(op_m, op_e, op_n, 0, 10, 0);
        force_done = 1'b1;
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (go || m_valid || !s_ready || !busy) viol++;
        end
        force_done = 1'b0;
        check("t5_ignore_done", 64'(viol), 0);
        send_range(op_m, op_e, op_n, 10, 3 * NW, 0);
        check("t5_arm_go", 64'(go), 0);
        wait_go("t5_go");
        recv(100, got, nrx);
        check("t5_result", 64'(diff_words(got, WIDTH'(8))), 0);

        // test 4: reset in LOAD_EXP at word 60, then a clean job
        op_m = WIDTH'(8); op_e = WIDTH'(13); op_n = WIDTH'(77);
        send_range(op_m, op_e, op_n, 0, NW + 60, 0);
        check("t4_busy_before", 64'(busy), 1);
        reset = 1'b1;
        #1;
        check("t4_rst_s_ready", 64'(s_ready), 0);
        check("t4_rst_busy", 64'(busy), 0);
        check("t4_rst_go", 64'(go), 0);
        check("t4_rst_m_valid", 64'(m_valid), 0);
        check("t4_rst_m_data", 64'(m_data), 0);
        check("t4_rst_operands", 64'(|{message, exponent, modulus}), 0);
        @(negedge clk);
        reset = 1'b0;
        send_range(op_m, op_e, op_n, 0, 3 * NW, 0);
        wait_go("t4_go");
        recv(100, got, nrx);
        check("t4_count", 64'(nrx), 64'(NW));
        check("t4_result", 64'(diff_words(got, WIDTH'(50))), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
